// File: rtl/ltc2308_responder.sv
// LTC2308 ADC emulator: answers CONVST/SCK/SDI from an on-chip master with
// data from an 8-entry channel register file, using the previous frame's config word.
module ltc2308_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        convst,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic [11:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic [5:0]  cfg
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [SYNC_STAGES:0]   convst_s;
  logic [SYNC_STAGES:0]   sck_s;
  logic [SYNC_STAGES-1:0] sdi_s;
  logic                   convst_rise;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   sdi_q;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [3:0]    bit_cnt;
  logic [4:0]    cfg_shift;
  logic [11:0]   shift_reg;
  logic [11:0]   ram [8];

  logic [2:0]  ch_p;
  logic [2:0]  ch_n;
  logic [12:0] diff;
  logic [11:0] result;

  // Top bit of each pin chain is the edge-detector history flop; the edge
  // pulse is registered so sdo lands SYNC_STAGES+2 clk after a pin change.
  always_ff @(posedge clk) begin
    if (reset) begin
      convst_s    <= '0;
      sck_s       <= '0;
      sdi_s       <= '0;
      convst_rise <= 1'b0;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      convst_s    <= (SYNC_STAGES+1)'({convst_s, convst});
      sck_s       <= (SYNC_STAGES+1)'({sck_s, sck});
      sdi_s       <= SYNC_STAGES'({sdi_s, sdi});
      convst_rise <= convst_s[SYNC_STAGES-1] & ~convst_s[SYNC_STAGES];
      sck_rise    <= sck_s[SYNC_STAGES-1] & ~sck_s[SYNC_STAGES];
      sck_fall    <= ~sck_s[SYNC_STAGES-1] & sck_s[SYNC_STAGES];
      sdi_q       <= sdi_s[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) ram[i] <= '0;
    end else if (wr_en) begin
      ram[wr_ch] <= wr_data;
    end
  end

  // Channel index is {S1,S0,O/S}; the differential partner flips O/S.
  assign ch_p = {cfg[3], cfg[2], cfg[4]};
  assign ch_n = {cfg[3], cfg[2], ~cfg[4]};

  always_comb begin
    diff = {1'b0, ram[ch_p]} - {1'b0, ram[ch_n]};
    if (cfg[5]) begin
      result = cfg[1] ? ram[ch_p] : (ram[ch_p] ^ 12'h800);
    end else if (cfg[1]) begin
      result = diff[12] ? '0 : diff[11:0];
    end else begin
      result = diff[12:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sdo        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg        <= 6'b100010;
      cfg_shift  <= '0;
      shift_reg  <= '0;
      count      <= '0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      // convst outranks any sck edge detected in the same cycle
      if (convst_rise && state != CONV) begin
        state     <= CONV;
        shift_reg <= result;
        count     <= CW'(CONV_CYCLES - 1);
        busy      <= 1'b1;
        sdo       <= 1'b0;
        bit_cnt   <= '0;
      end else begin
        case (state)
          IDLE: sdo <= 1'b0;
          CONV: begin
            if (count == '0) begin
              state   <= SHIFT;
              busy    <= 1'b0;
              sdo     <= shift_reg[11];
              bit_cnt <= '0;
            end else begin
              count <= count - 1'b1;
            end
          end
          SHIFT: begin
            if (sck_rise) begin
              if (bit_cnt < 4'd5) cfg_shift <= {cfg_shift[3:0], sdi_q};
              if (bit_cnt == 4'd5) cfg <= {cfg_shift, sdi_q};
              if (bit_cnt == 4'd11) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
              bit_cnt <= bit_cnt + 1'b1;
            end else if (sck_fall) begin
              shift_reg <= {shift_reg[10:0], 1'b0};
              sdo       <= shift_reg[10];
            end
          end
          default: begin
            if (sck_fall) sdo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
